ts_trip_seq: RTL
================

TS_TRIP_SEQ -- requirements
Module: ts_trip_seq

Interface
REQ-001 SHALL have parameter N_CH, default 10: number of temperature-servo channels.
REQ-002 SHALL have parameter HOLD, default 1_000_000: hold-off clk cycles after clear, ≥1.
REQ-003 SHALL have parameter STAGGER, default 100_000: clk cycles per channel re-enable slot, ≥1.
REQ-004 SHALL have clk  input  1  system clock; all logic on posedge clk.
REQ-005 SHALL have rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have ts_on_in  input  N_CH  requested servo enables.
REQ-007 SHALL have fault  input  N_CH  per-channel fault, level, synchronous to clk.
REQ-008 SHALL have clr  input  1  re-arm request, one-cycle pulse.
REQ-009 SHALL have ts_on_out  output  N_CH  gated servo enables, registered.
REQ-010 SHALL have tripped  output  N_CH  per-channel trip latch, registered.
REQ-011 SHALL have busy  output  1  high while state is HOLD or STAG.

Function
REQ-012 SHALL set tripped[i] at the edge following any cycle with fault[i]=1, regardless of ts_on_in[i] or state.
REQ-013 SHALL register ts_on_out[i] = ts_on_in[i] & ~fault[i] & ~tripped[i] each cycle: one-cycle latency, fault forces 0 at the next edge.
REQ-014 SHALL implement FSM with states IDLE, HOLD, STAG; busy = (state != IDLE).
REQ-015 IDLE: clr=1 with tripped != 0 SHALL go to HOLD with hold counter 0; clr with tripped == 0 SHALL be ignored.
REQ-016 HOLD: counter increments each cycle; at count HOLD-1 SHALL go to STAG with slot index 0 and slot counter 0 (exactly HOLD cycles in HOLD).
REQ-017 STAG: each index k = 0..N_CH-1 SHALL occupy exactly STAGGER cycles, including non-tripped indices.
REQ-018 On the first cycle of slot k, tripped[k] SHALL be cleared if fault[k]=0; kept if fault[k]=1.
REQ-019 After the last cycle of slot N_CH-1, SHALL return to IDLE.
REQ-020 clr while busy SHALL be ignored.
REQ-021 Fault and release for the same channel in the same cycle: fault SHALL win (tripped stays 1).
REQ-022 A channel tripping during HOLD, or during STAG after its slot, SHALL remain tripped until a later clr sequence.
REQ-023 Counters SHALL be 32-bit, unsigned, and never wrap within a sequence.

Reset
REQ-024 rst SHALL force state IDLE, all counters and index 0, tripped=0, ts_on_out=0, busy=0 at the next edge.
REQ-025 rst mid-sequence SHALL abort it; no trips or releases are retained.
REQ-026 rst SHALL take priority over fault and clr in the same cycle.

Configuration
REQ-027 Macro TS_TRIP_CNT_EN defined: SHALL add output trip_cnt  16  count of cycles in which at least one tripped bit rose 0->1.
REQ-028 trip_cnt SHALL saturate at 0xFFFF and be cleared only by rst.
REQ-029 Macro TS_TRIP_CNT_EN undefined: trip_cnt port and logic SHALL be absent; all other behaviour unchanged.

Verification (N_CH=4, HOLD=4, STAGGER=3)
REQ-030 ts_on_in=4'hF, fault=0 after rst -> ts_on_out=4'hF one cycle later; tripped=0; busy=0.
REQ-031 fault=4'b0100 for 1 cycle at t -> tripped=4'b0100 and ts_on_out[2]=0 from t+1; ts_on_out[2] stays 0 after fault drops.
REQ-032 tripped=4'b0101, clr at t, faults clear -> busy from t+1; tripped[0] clears at t+6; tripped[2] at t+12; ts_on_out 4'hF at t+13; busy=0 at t+17.
REQ-033 Same as REQ-032 but fault[2] held high -> tripped ends 4'b0100; ts_on_out=4'b1011; clr at t+2 ignored.
REQ-034 rst at t+8 mid-sequence -> t+9: tripped=0, busy=0, ts_on_out=0; one cycle later ts_on_out=ts_on_in.
REQ-035 With TS_TRIP_CNT_EN: faults rising on channels 0 and 1 in one cycle, then channel 3 later -> trip_cnt=2; forced 0xFFFF plus one trip -> stays 0xFFFF.

Source files
------------

// File: rtl/ts_trip_seq.sv
// ts_trip_seq: latches per-channel servo trips and re-arms them one slot at a time after a clear.
// Define TS_TRIP_CNT_EN to add the saturating trip_cnt output.
module ts_trip_seq #(
  parameter int N_CH    = 10,
  parameter int HOLD    = 1_000_000,
  parameter int STAGGER = 100_000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] ts_on_in,
  input  logic [N_CH-1:0] fault,
  input  logic            clr,
  output logic [N_CH-1:0] ts_on_out,
  output logic [N_CH-1:0] tripped,
`ifdef TS_TRIP_CNT_EN
  output logic [15:0]     trip_cnt,
`endif
  output logic            busy
);
  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_STAG} state_t;
  state_t state_q, state_d;
  logic [31:0] cnt_q, cnt_d, idx_q, idx_d;
  logic [N_CH-1:0] trip_q, trip_d, on_q, rel;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    idx_d = idx_q;
    rel = '0;
    case (state_q)
      S_IDLE: if (clr && |trip_q) begin
        state_d = S_HOLD;
        cnt_d = '0;
      end
      S_HOLD: if (cnt_q == 32'(HOLD - 1)) begin
        state_d = S_STAG;
        cnt_d = '0;
        idx_d = '0;
      end else cnt_d = cnt_q + 32'd1;
      S_STAG: begin
        rel = (cnt_q == '0) ? N_CH'(1) << idx_q : '0;
        if (cnt_q == 32'(STAGGER - 1)) begin
          cnt_d = '0;
          state_d = (idx_q == 32'(N_CH - 1)) ? S_IDLE : S_STAG;
          idx_d = (idx_q == 32'(N_CH - 1)) ? '0 : idx_q + 32'd1;
        end else cnt_d = cnt_q + 32'd1;
      end
      default: state_d = S_IDLE;
    endcase
    // an active fault overrides a release landing in the same cycle
    trip_d = (trip_q & ~rel) | fault;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      idx_q <= '0;
      trip_q <= '0;
      on_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      trip_q <= trip_d;
      on_q <= ts_on_in & ~fault & ~trip_q;
    end
  end
`ifdef TS_TRIP_CNT_EN
  logic [15:0] tc_q;
  always_ff @(posedge clk) begin
    if (rst) tc_q <= '0;
    else if (|(trip_d & ~trip_q) && tc_q != 16'hFFFF) tc_q <= tc_q + 16'd1;
  end
  assign trip_cnt = tc_q;
`endif
  assign ts_on_out = on_q;
  assign tripped = trip_q;
  assign busy = state_q != S_IDLE;
endmodule
